mux81_result_checker: RTL

Registered checker stage that sits directly downstream of the 8-to-1 MUX DUT. It consumes the DUT's `{Y, W}` output pair on a sample strobe and compares it against a golden 2-bit table held in internal memory. It counts verified vectors and mismatches, and reports completion. It replaces the ad-hoc per-vector verify task with a clocked, reusable block that both the testbench and emulation builds can instantiate.

---
 rtl/mux81_result_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mux81_result_checker.sv
// mux81_result_checker: clocked checker for the 8-to-1 MUX {Y, W} outputs.
// Compares each sampled output pair against a golden 2-bit table, counts
// checked vectors and mismatches, and records the most recent failure.
module mux81_result_checker #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [1:0]    load_data,
    input  logic [AW:0]   num_vectors,
    input  logic          start,
    input  logic          abort,
    input  logic          sample,
    input  logic          y_l,
    input  logic          w_l,
    output logic          busy,
    output logic          done,
    output logic          mismatch,
    output logic [AW:0]   v_cnt,
    output logic [AW:0]   e_cnt,
    output logic [1:0]    last_got,
    output logic [1:0]    last_exp
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   target_q;
    logic [CW-1:0]   target_d;
    logic [CW-1:0]   v_cnt_d;
    logic [CW-1:0]   e_cnt_d;
    logic [1:0]      last_got_d;
    logic [1:0]      last_exp_d;
    logic            mismatch_d;

    logic [1:0]      mem [DEPTH];

    logic [1:0]      got_c;
    logic [1:0]      exp_c;
    logic            miss_c;
    logic [CW-1:0]   target_clamp_c;
    logic            load_ok_c;

    // Golden-table read port and compare; case inequality so X/Z on the DUT fails.
    always_comb begin
        got_c          = {y_l, w_l};
        exp_c          = mem[v_cnt[AW-1:0]];
        miss_c         = (got_c !== exp_c);
        target_clamp_c = (32'(num_vectors) > DEPTH) ? CW'(DEPTH) : num_vectors;
        load_ok_c      = load_we && (state_q != ST_RUN) && (32'(load_addr) < DEPTH);
    end

    // Golden table write port; not reset so contents survive a reset.
    always_ff @(posedge clock) begin
        if (load_ok_c) begin
            mem[load_addr] <= load_data;
        end
    end

    // Next-state and next-value logic for the run controller and counters.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        v_cnt_d    = v_cnt;
        e_cnt_d    = e_cnt;
        last_got_d = last_got;
        last_exp_d = last_exp;
        mismatch_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    target_d   = target_clamp_c;
                    v_cnt_d    = '0;
                    e_cnt_d    = '0;
                    last_got_d = 2'b00;
                    last_exp_d = 2'b00;
                end
            end
            ST_RUN: begin
                if (sample) begin
                    v_cnt_d = v_cnt + CW'(1);
                    if (miss_c) begin
                        e_cnt_d    = e_cnt + CW'(1);
                        mismatch_d = 1'b1;
                        last_got_d = got_c;
                        last_exp_d = exp_c;
                    end
                end
                // Abort wins over completion; a same-edge sample is still counted.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (v_cnt_d == target_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            v_cnt    <= '0;
            e_cnt    <= '0;
            last_got <= 2'b00;
            last_exp <= 2'b00;
            mismatch <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            v_cnt    <= v_cnt_d;
            e_cnt    <= e_cnt_d;
            last_got <= last_got_d;
            last_exp <= last_exp_d;
            mismatch <= mismatch_d;
            busy     <= (state_d == ST_RUN);
            done     <= (state_d == ST_DONE);
        end
    end

endmodule
